// File: rtl/secded_pipe_decoder_pkg.sv
// secded_pkg -- shared definitions for the SECDED pipelined decoder.
//   calc_chk_w : total check width (Hamming bits + overall parity) for a data width
//   pos_to_idx : codeword position -> data bit index (-1 for parity positions)
//   ham_mask   : data-bit mask feeding Hamming check bit j
//   err_class_e: per-word classification
package secded_pkg;

  typedef enum logic [1:0] {CLEAN, SEC, DED} err_class_e;

  // Smallest P with 2^P >= data_w + P + 1, plus one bit for overall parity.
  function automatic int calc_chk_w(input int data_w);
    int p;
    p = 1;
    while ((1 << p) < data_w + p + 1) p++;
    return p + 1;
  endfunction

  // Data bits fill the non-power-of-two positions from 3 upward, so a
  // position's data index is its rank minus the parity slots below it.
  function automatic int pos_to_idx(input int pos);
    int idx;
    idx = -1;
    if (pos >= 3 && (pos & (pos - 1)) != 0) begin
      idx = pos - 1;
      for (int j = 0; j < 8; j++)
        if ((1 << j) < pos) idx--;
    end
    return idx;
  endfunction

  function automatic logic [63:0] ham_mask(input int data_w, input int p, input int j);
    logic [63:0] m;
    int          idx;
    m = '0;
    for (int pos = 3; pos <= data_w + p; pos++) begin
      idx = pos_to_idx(pos);
      if (idx >= 0 && ((pos >> j) & 1) != 0) m[idx] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/secded_pipe_decoder_if.sv
// secded_pipe_decoder_if -- input and output handshake bundle of the decoder.
//   id_*  : received word, check bits, correction enable, valid/ready
//   od_*  : delivered word, flags, {parity mismatch, syndrome}, valid/ready
//   master: producer/consumer side (testbench or surrounding logic)
//   slave : decoder side
interface secded_pipe_decoder_if
  import secded_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CHK_W  = calc_chk_w(DATA_W)
);
  logic [DATA_W-1:0] id_data;
  logic [CHK_W-1:0]  id_chk;
  logic              id_valid;
  logic              id_ready;
  logic              id_cor_en;
  logic [DATA_W-1:0] od_data;
  logic              od_valid;
  logic              od_ready;
  logic              od_sec;
  logic              od_ded;
  logic [CHK_W-1:0]  od_syn;

  modport master (
    output id_data, id_chk, id_valid, id_cor_en, od_ready,
    input  id_ready, od_data, od_valid, od_sec, od_ded, od_syn
  );

  modport slave (
    input  id_data, id_chk, id_valid, id_cor_en, od_ready,
    output id_ready, od_data, od_valid, od_sec, od_ded, od_syn
  );
endinterface

// File: rtl/secded_pipe_decoder_syndrome.sv
// secded_syndrome -- combinational Hamming syndrome and overall parity check.
//   data    : data word
//   chk     : received check bits ([P-1:0] Hamming, [P] overall parity)
//   syn     : recomputed Hamming bits XOR received Hamming bits
//   par_err : XOR over data and all check bits (1 = overall parity mismatch)
// As an encoder: tie chk to zero; syn is then the Hamming check bits and the
// overall parity bit is par_err ^ (^syn).
module secded_syndrome
  import secded_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CHK_W  = calc_chk_w(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [CHK_W-1:0]  chk,
  output logic [CHK_W-2:0]  syn,
  output logic              par_err
);
  localparam int P = CHK_W - 1;

  for (genvar j = 0; j < P; j++) begin : g_ham
    localparam logic [63:0] MASK = ham_mask(DATA_W, P, j);
    assign syn[j] = (^(data & MASK[DATA_W-1:0])) ^ chk[j];
  end

  assign par_err = ^{data, chk};
endmodule

// File: rtl/secded_pipe_decoder.sv
// secded_pipe_decoder -- two-stage SECDED decoder with error counters.
//   id_clk, id_rst : clock, asynchronous active-high reset
//   id_clr         : synchronous clear of both counters (wins over increments)
//   bus            : input word/check/cor_en handshake and output word/flags handshake
//   od_cnt_sec/ded : saturating counts of delivered single / double error words
module secded_pipe_decoder
  import secded_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CHK_W  = calc_chk_w(DATA_W),
  parameter int CNT_W  = 16
) (
  input  logic                 id_clk,
  input  logic                 id_rst,
  input  logic                 id_clr,
  secded_pipe_decoder_if.slave bus,
  output logic [CNT_W-1:0]     od_cnt_sec,
  output logic [CNT_W-1:0]     od_cnt_ded
);
  localparam int P = CHK_W - 1;
  // Highest codeword position in use; larger syndromes cannot be single errors.
  localparam logic [P-1:0] LAST_POS = P'(DATA_W + P);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic              ld_p1, ld_p2, hs;
  logic [P-1:0]      syn_c;
  logic              par_c;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [P-1:0]      syn_p1;
  logic              par_p1, cor_en_p1;
  err_class_e        cls;
  logic [DATA_W-1:0] flip, data_c;
  logic              vld_p2;
  logic [DATA_W-1:0] data_p2;
  logic [CHK_W-1:0]  syn_p2;
  logic              sec_p2, ded_p2;

  assign ld_p2        = !vld_p2 || bus.od_ready;
  assign ld_p1        = !vld_p1 || ld_p2;
  assign bus.id_ready = ld_p1 && !id_rst;
  assign hs           = vld_p2 && bus.od_ready;

  secded_syndrome #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_syn (
    .data    (bus.id_data),
    .chk     (bus.id_chk),
    .syn     (syn_c),
    .par_err (par_c)
  );

  // ---- stage 1: syndrome and parity mismatch ----
  always_ff @(posedge id_clk or posedge id_rst) begin
    if (id_rst)     vld_p1 <= 1'b0;
    else if (ld_p1) vld_p1 <= bus.id_valid;
  end

  always_ff @(posedge id_clk) begin
    if (ld_p1 && bus.id_valid) begin
      data_p1   <= bus.id_data;
      syn_p1    <= syn_c;
      par_p1    <= par_c;
      cor_en_p1 <= bus.id_cor_en;
    end
  end

  // One-hot correction mask: set only when the syndrome names a data position.
  for (genvar g = 1; g <= DATA_W + P; g++) begin : g_flip
    localparam int IDX = pos_to_idx(g);
    if (IDX >= 0) begin : g_dat
      assign flip[IDX] = (syn_p1 == P'(g));
    end
  end

  always_comb begin
    cls = CLEAN;
    if (par_p1)              cls = (syn_p1 <= LAST_POS) ? SEC : DED;
    else if (syn_p1 != '0)   cls = DED;
    data_c = data_p1;
    if (cls == SEC && cor_en_p1) data_c = data_p1 ^ flip;
  end

  // ---- stage 2: corrected data and flags ----
  always_ff @(posedge id_clk or posedge id_rst) begin
    if (id_rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      syn_p2  <= '0;
      sec_p2  <= 1'b0;
      ded_p2  <= 1'b0;
    end else if (ld_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= data_c;
        syn_p2  <= {par_p1, syn_p1};
        sec_p2  <= (cls == SEC);
        ded_p2  <= (cls == DED);
      end
    end
  end

  assign bus.od_valid = vld_p2;
  assign bus.od_data  = data_p2;
  assign bus.od_syn   = syn_p2;
  assign bus.od_sec   = sec_p2;
  assign bus.od_ded   = ded_p2;

  // ---- error counters, advanced on delivery ----
  always_ff @(posedge id_clk or posedge id_rst) begin
    if (id_rst) begin
      od_cnt_sec <= '0;
      od_cnt_ded <= '0;
    end else if (id_clr) begin
      od_cnt_sec <= '0;
      od_cnt_ded <= '0;
    end else if (hs) begin
      if (sec_p2) od_cnt_sec <= sat_inc(od_cnt_sec);
      if (ded_p2) od_cnt_ded <= sat_inc(od_cnt_ded);
    end
  end
endmodule

// File: tb/tb_secded_pipe_decoder.sv
// tb_secded_pipe_decoder -- scoreboard bench for secded_pipe_decoder (DATA_W=32).
module tb_secded_pipe_decoder;
  localparam int DATA_W = 32;
  localparam int CHK_W  = 7;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [31:0] data;
    logic        sec;
    logic        ded;
    logic [6:0]  syn;
  } exp_t;

  logic             id_clk = 1'b0;
  logic             id_rst;
  logic             id_clr;
  logic [CNT_W-1:0] od_cnt_sec, od_cnt_ded;

  secded_pipe_decoder_if #(.DATA_W(DATA_W), .CHK_W(CHK_W)) bus ();

  secded_pipe_decoder #(.DATA_W(DATA_W), .CHK_W(CHK_W), .CNT_W(CNT_W)) dut (
    .id_clk     (id_clk),
    .id_rst     (id_rst),
    .id_clr     (id_clr),
    .bus        (bus),
    .od_cnt_sec (od_cnt_sec),
    .od_cnt_ded (od_cnt_ded)
  );

  always #5 id_clk = ~id_clk;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Independent encoder: Hamming bits are the XOR of the positions of all set data bits.
  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [5:0] h;
    int         pos;
    h   = '0;
    pos = 2;
    for (int i = 0; i < 32; i++) begin
      pos++;
      while ((pos & (pos - 1)) == 0) pos++;
      if (d[i]) h ^= pos[5:0];
    end
    return {(^d) ^ (^h), h};
  endfunction

  task automatic send(input logic [31:0] d, input logic [6:0] c, input logic cen, input exp_t e);
    int n;
    n = 0;
    bus.id_data   = d;
    bus.id_chk    = c;
    bus.id_cor_en = cen;
    bus.id_valid  = 1'b1;
    do begin
      @(negedge id_clk);
      n++;
    end while (!bus.id_ready && n < 50);
    if (bus.id_ready) sbq.push_back(e);
    else check("accept_timeout", 64'(bus.id_ready), 64'd1);
    @(posedge id_clk);
    #1;
    bus.id_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || bus.od_valid) && n < 100) begin
      @(posedge id_clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  // Monitor: pops on every output handshake and checks stability while stalled.
  initial begin
    exp_t cur, held, e;
    logic held_v;
    held_v = 1'b0;
    forever begin
      @(negedge id_clk);
      if (id_rst) begin
        held_v = 1'b0;
      end else begin
        cur = '{data: bus.od_data, sec: bus.od_sec, ded: bus.od_ded, syn: bus.od_syn};
        if (held_v && bus.od_valid) check("stall_hold", 64'(cur), 64'(held));
        if (bus.od_valid && bus.od_ready) begin
          if (sbq.size() == 0) begin
            check("unexpected_output", 64'(cur), 64'd0);
          end else begin
            e = sbq.pop_front();
            check("output_word", 64'(cur), 64'(e));
          end
          held_v = 1'b0;
        end else if (bus.od_valid) begin
          held_v = 1'b1;
          held   = cur;
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  c_ref;
    logic [31:0] bp_d [4];
    int          idx;
    bp_d = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004};

    id_rst        = 1'b1;
    id_clr        = 1'b0;
    bus.id_valid  = 1'b0;
    bus.id_data   = '0;
    bus.id_chk    = '0;
    bus.id_cor_en = 1'b0;
    bus.od_ready  = 1'b1;
    repeat (2) @(posedge id_clk);
    @(negedge id_clk);
    check("rst_od_valid", 64'(bus.od_valid), 64'd0);
    check("rst_od_data",  64'(bus.od_data), 64'd0);
    check("rst_od_syn",   64'(bus.od_syn), 64'd0);
    check("rst_flags",    64'({bus.od_sec, bus.od_ded}), 64'd0);
    check("rst_counters", 64'({od_cnt_sec, od_cnt_ded}), 64'd0);
    check("rst_id_ready", 64'(bus.id_ready), 64'd0);
    @(posedge id_clk);
    #1;
    id_rst = 1'b0;
    #1;
    check("post_rst_id_ready", 64'(bus.id_ready), 64'd1);

    c_ref = enc(32'hDEADBEEF);

    // Clean word and two-cycle latency
    send(32'hDEADBEEF, c_ref, 1'b1, '{32'hDEADBEEF, 1'b0, 1'b0, 7'h00});
    check("latency_c1", 64'(bus.od_valid), 64'd0);
    @(posedge id_clk);
    #1;
    check("latency_c2", 64'(bus.od_valid), 64'd1);
    drain();
    check("cnt_clean", 64'({od_cnt_sec, od_cnt_ded}), 64'd0);

    // Data bit 5 flipped, corrected
    send(32'hDEADBECF, c_ref, 1'b1, '{32'hDEADBEEF, 1'b1, 1'b0, 7'h4A});
    drain();
    check("cnt_sec_1", 64'(od_cnt_sec), 64'd1);

    // Data bits 0 and 1 flipped: uncorrectable
    send(32'hDEADBEEC, c_ref, 1'b1, '{32'hDEADBEEC, 1'b0, 1'b1, 7'h06});
    drain();
    check("cnt_ded_1", 64'(od_cnt_ded), 64'd1);

    // Bit 5 flipped, correction disabled
    send(32'hDEADBECF, c_ref, 1'b0, '{32'hDEADBECF, 1'b1, 1'b0, 7'h4A});
    // Hamming check bit 2 flipped
    send(32'hDEADBEEF, c_ref ^ 7'h04, 1'b1, '{32'hDEADBEEF, 1'b1, 1'b0, 7'h44});
    // Overall parity bit flipped
    send(32'hDEADBEEF, c_ref ^ 7'h40, 1'b1, '{32'hDEADBEEF, 1'b1, 1'b0, 7'h40});
    // Every check bit flipped: syndrome 63 lies beyond position 38
    send(32'hDEADBEEF, c_ref ^ 7'h7F, 1'b1, '{32'hDEADBEEF, 1'b0, 1'b1, 7'h7F});
    // Highest data bit (position 38) flipped
    send(32'h7FFFFFFF, enc(32'hFFFFFFFF), 1'b1, '{32'hFFFFFFFF, 1'b1, 1'b0, 7'h66});
    // All-zero clean word
    send(32'h00000000, 7'h00, 1'b1, '{32'h00000000, 1'b0, 1'b0, 7'h00});
    drain();
    check("cnt_sec_5", 64'(od_cnt_sec), 64'd5);
    check("cnt_ded_2", 64'(od_cnt_ded), 64'd2);

    // Backpressure: consumer stalled for five cycles under four back-to-back words
    bus.od_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
      bus.id_data   = bp_d[idx];
      bus.id_chk    = enc(bp_d[idx]);
      bus.id_cor_en = 1'b1;
      bus.id_valid  = 1'b1;
      @(negedge id_clk);
      if (bus.id_ready) begin
        sbq.push_back('{bp_d[idx], 1'b0, 1'b0, 7'h00});
        idx++;
      end
      @(posedge id_clk);
      #1;
      if (cyc == 4) begin
        check("bp_accepted_while_stalled", 64'(idx), 64'd2);
        check("bp_id_ready_low", 64'(bus.id_ready), 64'd0);
        bus.od_ready = 1'b1;
      end
    end
    bus.id_valid = 1'b0;
    check("bp_all_accepted", 64'(idx), 64'd4);
    drain();

    // Clear coinciding with a single-error delivery
    bus.od_ready = 1'b0;
    send(32'hDEADBECF, c_ref, 1'b1, '{32'hDEADBEEF, 1'b1, 1'b0, 7'h4A});
    @(posedge id_clk);
    #1;
    check("clr_word_parked", 64'(bus.od_valid), 64'd1);
    id_clr       = 1'b1;
    bus.od_ready = 1'b1;
    @(posedge id_clk);
    #1;
    id_clr = 1'b0;
    check("clr_priority_sec", 64'(od_cnt_sec), 64'd0);
    check("clr_priority_ded", 64'(od_cnt_ded), 64'd0);
    drain();

    // Saturation: 65536 single-error words from zero
    for (int i = 0; i < 65536; i++)
      send(32'hDEADBECF, c_ref, 1'b1, '{32'hDEADBEEF, 1'b1, 1'b0, 7'h4A});
    drain();
    check("cnt_sec_saturated", 64'(od_cnt_sec), 64'hFFFF);
    check("cnt_ded_after_sat", 64'(od_cnt_ded), 64'd0);

    // Reset with two words in flight
    send(32'h11111111, enc(32'h11111111), 1'b1, '{32'h11111111, 1'b0, 1'b0, 7'h00});
    send(32'h22222222, enc(32'h22222222), 1'b1, '{32'h22222222, 1'b0, 1'b0, 7'h00});
    id_rst = 1'b1;
    #1;
    check("midrst_od_valid", 64'(bus.od_valid), 64'd0);
    check("midrst_id_ready", 64'(bus.id_ready), 64'd0);
    sbq.delete();
    @(posedge id_clk);
    #1;
    id_rst = 1'b0;
    #1;
    check("after_rst_od_valid", 64'(bus.od_valid), 64'd0);
    check("after_rst_cnt_sec", 64'(od_cnt_sec), 64'd0);
    check("after_rst_id_ready", 64'(bus.id_ready), 64'd1);
    repeat (3) @(posedge id_clk);
    #1;
    check("after_rst_no_output", 64'(bus.od_valid), 64'd0);
    send(32'h33333333, enc(32'h33333333), 1'b1, '{32'h33333333, 1'b0, 1'b0, 7'h00});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/secded_pipe_decoder.md
SECDED_PIPE_DECODER -- requirements
Module: secded_pipe_decoder

Interface
REQ-001 Parameter DATA_W, default 32: data word width, range 4..64.
REQ-002 Parameter CHK_W, default derived as P+1: P is the smallest integer with 2^P >= DATA_W+P+1, giving 7 for DATA_W=32.
REQ-003 Parameter CNT_W, default 16: width of the error counters.
REQ-004 id_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 id_rst  in  1  asynchronous, active-high reset.
REQ-006 id_data  in  DATA_W  received data word.
REQ-007 id_chk  in  CHK_W  received check bits; [P-1:0] are Hamming bits, [P] is overall parity.
REQ-008 id_valid / id_ready  in / out  1  input handshake.
REQ-009 id_cor_en  in  1  correction enable, sampled with each accepted word.
REQ-010 id_clr  in  1  synchronous clear of both counters.
REQ-011 od_data  out  DATA_W  delivered word, corrected or passed through.
REQ-012 od_valid / od_ready  out / in  1  output handshake.
REQ-013 od_sec, od_ded  out  1  per-word flags: single error, double (uncorrectable) error.
REQ-014 od_syn  out  CHK_W  {parity mismatch, syndrome} for the delivered word.
REQ-015 od_cnt_sec, od_cnt_ded  out  CNT_W  saturating error counters.

Function
REQ-016 Code mapping: data bit i SHALL occupy the i-th non-power-of-two codeword position, counting 1-based from 3 (positions 3,5,6,7,9,...).
REQ-017 Check bit j SHALL be the XOR of all data bits whose position has bit j set.
REQ-018 id_chk[P] SHALL be the XOR of all data bits and id_chk[P-1:0].
REQ-019 Syndrome s = recomputed Hamming bits XOR received bits; p = overall parity mismatch.
REQ-020 Classification:
- s=0, p=0: clean.
- p=1 and s is 0, a power of two, or a data position: single error; od_sec=1.
- p=0 and s!=0: od_ded=1.
- p=1 and s beyond the last valid position: od_ded=1.
REQ-021 Correction: when od_sec=1, id_cor_en=1 and s maps to a data bit, that bit SHALL be inverted in od_data; all other cases pass id_data through unchanged.
REQ-022 Flags and od_syn SHALL be reported regardless of id_cor_en.
REQ-023 Pipeline has two stages: S1 registers the syndrome and parity, S2 registers the corrected data and flags; latency is 2 cycles from input handshake to od_valid when unstalled.
REQ-024 Stage-advance rule: S2 loads when it is empty or od_ready=1. S1 loads when it is empty or S2 loads. id_ready = S1 empty or S1 advancing.
REQ-025 While od_valid=1 and od_ready=0, od_data, od_sec, od_ded and od_syn SHALL hold stable.
REQ-026 Throughput is one word per cycle; no word is dropped or duplicated under any backpressure pattern.
REQ-027 Counters increment only on an output handshake (od_valid & od_ready) with the matching flag set, and saturate at all-ones.
REQ-028 id_clr has priority over an increment in the same cycle: the counter becomes 0.
REQ-029 When id_valid=0, stage contents SHALL not change except by advancing.

Reset
REQ-030 On id_rst: both stage valids = 0, od_valid = 0, od_data/od_syn = 0, od_sec = od_ded = 0, counters = 0.
REQ-031 Asserting reset mid-stream discards in-flight words.
REQ-032 During reset, id_ready SHALL read 1 only after reset deasserts.

Structure
REQ-033 Package secded_pkg SHALL hold:
- the CHK_W derivation function
- the position-to-data-index mapping function
- the classification enum {CLEAN, SEC, DED}.
REQ-034 The purely combinational check-bit and syndrome generator SHALL be sub-module secded_syndrome; it is also usable for encoding.

Verification
REQ-035 DATA_W=32, data 0xDEADBEEF with correct check bits -> od_data=0xDEADBEEF, od_sec=0, od_ded=0, od_syn=0, 2-cycle latency.
REQ-036 Same word with data bit 5 flipped, id_cor_en=1 -> od_data=0xDEADBEEF, od_sec=1, od_syn[5:0]=10, od_cnt_sec=1.
REQ-037 Data bits 0 and 1 flipped -> od_ded=1, od_data=0xDEADBEEC (uncorrected), od_cnt_ded=1.
REQ-038 Bit 5 flipped with id_cor_en=0 -> od_data=0xDEADBECF, od_sec=1.
REQ-039 Backpressure: 4 back-to-back words with od_ready=0 for 5 cycles -> id_ready drops after 2 accepted, all 4 words delivered in order, outputs stable while stalled.
REQ-040 Saturation and reset:
- 65536 single-error words -> od_cnt_sec=0xFFFF.
- id_clr coinciding with an increment -> 0.
- id_rst mid-stream -> od_valid=0 next cycle.
